fifo_ctrl: RTL and testbench

//   Pointer/flag controller that turns the dual-port 8-bit ram into a

---
 rtl/fifo_ctrl.sv | 66 ++++++
 tb/tb_fifo_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller that turns a dual-port async-read ram into a
// first-word-fall-through FIFO with sticky overflow/underflow flags.
module fifo_ctrl #(
    parameter int AWIDTH   = 3,
    parameter int AF_LEVEL = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              clr_err,
    output logic              w_en,
    output logic [AWIDTH-1:0] waddress,
    output logic [AWIDTH-1:0] raddress,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AWIDTH:0] AF_THR = AF_LEVEL[AWIDTH:0];

    logic [AWIDTH:0] wptr;
    logic [AWIDTH:0] rptr;
    logic            do_wr;
    logic            do_rd;

    assign waddress    = wptr[AWIDTH-1:0];
    assign raddress    = rptr[AWIDTH-1:0];
    assign empty       = (wptr == rptr);
    assign full        = (wptr[AWIDTH] != rptr[AWIDTH]) &&
                         (wptr[AWIDTH-1:0] == rptr[AWIDTH-1:0]);
    assign count       = wptr - rptr;
    assign almost_full = (count >= AF_THR);

    // Reset gates the write strobe so the ram is never written while held in reset.
    assign do_wr = push & ~full & ~reset;
    assign do_rd = pop & ~empty;
    assign w_en  = do_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full)      overflow <= 1'b1;
            else if (clr_err)      overflow <= 1'b0;
            if (pop && empty)      underflow <= 1'b1;
            else if (clr_err)      underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a ram model plus a queue-based FIFO
// reference, driven by directed and randomized push/pop sequences.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic       pop;
    logic       clr_err;
    logic [7:0] wdata;
    logic       w_en;
    logic [2:0] waddress;
    logic [2:0] raddress;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    logic [7:0] mem [8];
    logic [7:0] rdata;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] q [$];
    bit         m_ovf;
    bit         m_udf;
    int         wr_total;
    logic       obs_wen;
    logic       exp_wen;
    logic [7:0] obs_rdata;
    logic [7:0] popped;
    bit         popped_valid;

    fifo_ctrl #(.AWIDTH(3), .AF_LEVEL(6)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .clr_err(clr_err),
        .w_en(w_en), .waddress(waddress), .raddress(raddress),
        .full(full), .empty(empty), .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (w_en) mem[waddress] <= wdata;
    assign rdata = mem[raddress];

    // One clock of stimulus; advances the reference queue, no comparisons.
    task automatic cycle(input logic p, input logic r, input logic c, input logic [7:0] d);
        bit fm, em;
        push = p; pop = r; clr_err = c; wdata = d;
        fm = (q.size() == 8);
        em = (q.size() == 0);
        exp_wen = p && !fm;
        #3;
        obs_wen   = w_en;
        obs_rdata = rdata;
        @(posedge clk);
        popped_valid = 1'b0;
        if (r && !em) begin
            popped = q.pop_front();
            popped_valid = 1'b1;
        end
        if (p && !fm) begin
            q.push_back(d);
            wr_total++;
        end
        if (p && fm) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (r && em) m_udf = 1'b1; else if (c) m_udf = 1'b0;
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; wr_total = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; wdata = '0;
        model_reset();
        #2;
        vectors++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 ||
            w_en !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: cnt=%0d e=%b f=%b af=%b wen=%b ov=%b un=%b, want 0 1 0 0 0 0 0",
                     count, empty, full, almost_full, w_en, overflow, underflow);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'h30 + 8'(i));
        vectors++;
        if (count !== 4'd3) begin
            errors++;
            $display("FAIL burst_count: got %0d want 3", count);
        end
        push = 1'b1; wdata = 8'h55;
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if (count !== 4'd0 || empty !== 1'b1 || w_en !== 1'b0 || waddress !== 3'd0 || raddress !== 3'd0) begin
            errors++;
            $display("FAIL reset_midburst: cnt=%0d e=%b wen=%b wa=%0d ra=%0d, want 0 1 0 0 0",
                     count, empty, w_en, waddress, raddress);
        end
        @(posedge clk); #1;
        vectors++;
        if (w_en !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: wen=%b cnt=%0d, want 0 0", w_en, count);
        end
        push = 1'b0;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'h10 + 8'(i));
            vectors++;
            if (count !== 4'(i + 1) || almost_full !== (i + 1 >= 6) || full !== (i == 7) || empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d: cnt=%0d af=%b f=%b e=%b, want %0d %b %b 0",
                         i, count, almost_full, full, empty, i + 1, (i + 1 >= 6), (i == 7));
            end
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
            vectors++;
            if (obs_rdata !== 8'h10 + 8'(i) || count !== 4'(7 - i)) begin
                errors++;
                $display("FAIL drain_%0d: rdata=%h cnt=%0d, want %h %0d", i, obs_rdata, count, 8'h10 + 8'(i), 7 - i);
            end
        end
        vectors++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL drained_flags: e=%b f=%b, want 1 0", empty, full);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i));
        cycle(1'b1, 1'b0, 1'b0, 8'hAA);
        vectors++;
        if (obs_wen !== 1'b0 || count !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow: wen=%b cnt=%0d ov=%b, want 0 8 1", obs_wen, count, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
            vectors++;
            if (obs_rdata !== 8'(i)) begin
                errors++;
                $display("FAIL ovf_drain_%0d: rdata=%h want %h", i, obs_rdata, 8'(i));
            end
        end
        vectors++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: e=%b ov=%b, want 1 1", empty, overflow);
        end
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        vectors++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ov=%b want 0", overflow);
        end
    endtask

    task automatic test_underflow();
        logic [2:0] ra;
        ra = raddress;
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        vectors++;
        if (raddress !== ra || count !== 4'd0 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow: ra=%0d cnt=%0d un=%b, want %0d 0 1", raddress, count, underflow, ra);
        end
        cycle(1'b0, 1'b1, 1'b1, 8'h00);
        vectors++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL udf_set_wins: un=%b want 1", underflow);
        end
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        vectors++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL udf_clear: un=%b want 0", underflow);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 8'h40 + 8'(i));
        cycle(1'b1, 1'b1, 1'b0, 8'h44);
        vectors++;
        if (count !== 4'd4 || obs_rdata !== 8'h40 || obs_wen !== 1'b1) begin
            errors++;
            $display("FAIL pp_mid: cnt=%0d rdata=%h wen=%b, want 4 40 1", count, obs_rdata, obs_wen);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
            vectors++;
            if (obs_rdata !== 8'h41 + 8'(i)) begin
                errors++;
                $display("FAIL pp_order_%0d: rdata=%h want %h", i, obs_rdata, 8'h41 + 8'(i));
            end
        end
        cycle(1'b1, 1'b1, 1'b0, 8'h5A);
        vectors++;
        if (count !== 4'd1 || underflow !== 1'b1 || empty !== 1'b0 || rdata !== 8'h5A) begin
            errors++;
            $display("FAIL pp_empty: cnt=%0d un=%b e=%b rdata=%h, want 1 1 0 5a", count, underflow, empty, rdata);
        end
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 8'h60 + 8'(i));
        cycle(1'b1, 1'b1, 1'b0, 8'hBB);
        vectors++;
        if (count !== 4'd7 || overflow !== 1'b1 || obs_wen !== 1'b0 || full !== 1'b0 || obs_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL pp_full: cnt=%0d ov=%b wen=%b f=%b rdata=%h, want 7 1 0 0 5a",
                     count, overflow, obs_wen, full, obs_rdata);
        end
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
            vectors++;
            if (obs_rdata !== 8'h60 + 8'(i)) begin
                errors++;
                $display("FAIL pp_full_order_%0d: rdata=%h want %h", i, obs_rdata, 8'h60 + 8'(i));
            end
        end
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_wrap();
        logic p, r, c;
        for (int i = 0; i < 60; i++) begin
            p = ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < 50);
            c = ($urandom_range(0, 99) < 10);
            cycle(p, r, c, 8'($urandom));
            vectors++;
            if (obs_wen !== exp_wen || (popped_valid && obs_rdata !== popped)) begin
                errors++;
                $display("FAIL wrap_io_%0d: wen=%b rdata=%h, want %b %h", i, obs_wen, obs_rdata, exp_wen, popped);
            end
            vectors++;
            if (count !== 4'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == 8) ||
                almost_full !== (q.size() >= 6) || overflow !== m_ovf || underflow !== m_udf ||
                waddress !== 3'(wr_total % 8) || (q.size() != 0 && rdata !== q[0])) begin
                errors++;
                $display("FAIL wrap_state_%0d: cnt=%0d e=%b f=%b af=%b ov=%b un=%b wa=%0d, want %0d ov=%b un=%b wa=%0d",
                         i, count, empty, full, almost_full, overflow, underflow, waddress,
                         q.size(), m_ovf, m_udf, wr_total % 8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
